// File: rtl/sum_acc_pkg.sv
// ============================================================================
// Module      : sum_acc_pkg
// Description : Shared types and constants for the batch sum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } sum_acc_state_t;

  // Widest accumulator supported; narrower saturation values are slices of this.
  localparam int unsigned C_MAX_ACC_WIDTH = 128;
  localparam logic [C_MAX_ACC_WIDTH-1:0] c_SAT_ONES = '1;

endpackage : sum_acc_pkg

`default_nettype wire

// File: rtl/sat_add.sv
// ============================================================================
// Module      : sat_add
// Description : Combinational unsigned add that clips to all-ones on carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_add
  import sum_acc_pkg::*;
#(
  parameter int unsigned W = 40
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sat  = w_full[W];
  assign o_sum  = w_full[W] ? c_SAT_ONES[W-1:0] : w_full[W-1:0];

endmodule : sat_add

`default_nettype wire

// File: rtl/sum_accumulator.sv
// ============================================================================
// Module      : sum_accumulator
// Description : Accumulates COUNT adder results into a saturating batch total
//               and presents it on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned COUNT     = 4,
  parameter int unsigned CNT_W     = $clog2(COUNT + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sum_valid,
  output logic                 o_sum_ready,
  input  logic [WIDTH-1:0]     i_sum,
  input  logic                 i_overflow,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_saturated
);

  if (ACC_WIDTH < WIDTH + 1) begin : g_acc_width_check
    $error("sum_accumulator: ACC_WIDTH must be >= WIDTH+1");
  end
  if (ACC_WIDTH > C_MAX_ACC_WIDTH) begin : g_acc_max_check
    $error("sum_accumulator: ACC_WIDTH exceeds supported maximum");
  end
  if (COUNT < 1) begin : g_count_check
    $error("sum_accumulator: COUNT must be >= 1");
  end

  sum_acc_state_t       state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 valid_q, valid_d;
  logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic                 out_sat_q, out_sat_d;

  logic                 w_beat;
  logic                 w_close;
  logic [ACC_WIDTH-1:0] w_addend;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_add_sat;
  logic [ACC_WIDTH-1:0] w_acc_upd;
  logic [CNT_W-1:0]     w_cnt_upd;
  logic                 w_sat_upd;

  assign o_sum_ready = (state_q == ACCUM);
  assign w_beat      = i_sum_valid && o_sum_ready;
  assign w_addend    = ACC_WIDTH'({i_overflow, i_sum});

  sat_add #(
    .W (ACC_WIDTH)
  ) u_sat_add (
    .i_a   (acc_q),
    .i_b   (w_addend),
    .o_sum (w_sum),
    .o_sat (w_add_sat)
  );

  // Values the batch would hold after this cycle's beat, if one is accepted.
  assign w_acc_upd = w_beat ? w_sum : acc_q;
  assign w_cnt_upd = w_beat ? (cnt_q + CNT_W'(1)) : cnt_q;
  assign w_sat_upd = sat_q | (w_beat & w_add_sat);

  assign w_close = (w_beat && (w_cnt_upd == CNT_W'(COUNT))) ||
                   (i_flush && ((cnt_q != '0) || w_beat));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    out_acc_d = out_acc_q;
    out_cnt_d = out_cnt_q;
    out_sat_d = out_sat_q;
    case (state_q)
      ACCUM: begin
        acc_d = w_acc_upd;
        cnt_d = w_cnt_upd;
        sat_d = w_sat_upd;
        if (w_close) begin
          state_d   = HOLD;
          valid_d   = 1'b1;
          out_acc_d = w_acc_upd;
          out_cnt_d = w_cnt_upd;
          out_sat_d = w_sat_upd;
        end
      end
      HOLD: begin
        // Handshake cycle is the bubble: no beat is taken while leaving HOLD.
        if (i_ready) begin
          state_d = ACCUM;
          valid_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      out_acc_q <= '0;
      out_cnt_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      out_acc_q <= out_acc_d;
      out_cnt_q <= out_cnt_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_acc       = out_acc_q;
  assign o_count     = out_cnt_q;
  assign o_saturated = out_sat_q;

  // Upstream must not offer data it cannot hold while we are not ready.
  a_no_dropped_beat : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_sum_valid && !o_sum_ready));

endmodule : sum_accumulator

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ============================================================================
// Module      : tb_sum_accumulator
// Description : Directed self-checking bench; two instances (ACC 40 and 33 bits)
//               share stimulus so saturation shows on the narrow one only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        sum_valid;
  logic [31:0] sum;
  logic        ovf;
  logic        flush;
  logic        ready;

  logic        a_sum_ready, a_valid, a_sat;
  logic [39:0] a_acc;
  logic [2:0]  a_count;
  logic        b_sum_ready, b_valid, b_sat;
  logic [32:0] b_acc;
  logic [2:0]  b_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.WIDTH(32), .ACC_WIDTH(40), .COUNT(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_sum_valid(sum_valid), .o_sum_ready(a_sum_ready),
    .i_sum(sum), .i_overflow(ovf), .i_flush(flush), .o_valid(a_valid),
    .i_ready(ready), .o_acc(a_acc), .o_count(a_count), .o_saturated(a_sat));

  sum_accumulator #(.WIDTH(32), .ACC_WIDTH(33), .COUNT(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_sum_valid(sum_valid), .o_sum_ready(b_sum_ready),
    .i_sum(sum), .i_overflow(ovf), .i_flush(flush), .o_valid(b_valid),
    .i_ready(ready), .o_acc(b_acc), .o_count(b_count), .o_saturated(b_sat));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic drive(input logic v, input logic o, input logic [31:0] s, input logic f);
    @(negedge clk);
    sum_valid = v;
    ovf       = o;
    sum       = s;
    flush     = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic check_a(input string tag, input logic v, input logic [39:0] acc,
                         input logic [2:0] cnt, input logic st);
    check({tag, ".a_valid"}, 64'(a_valid), 64'(v));
    check({tag, ".a_acc"},   64'(a_acc),   64'(acc));
    check({tag, ".a_count"}, 64'(a_count), 64'(cnt));
    check({tag, ".a_sat"},   64'(a_sat),   64'(st));
  endtask

  task automatic check_b(input string tag, input logic v, input logic [32:0] acc,
                         input logic [2:0] cnt, input logic st);
    check({tag, ".b_valid"}, 64'(b_valid), 64'(v));
    check({tag, ".b_acc"},   64'(b_acc),   64'(acc));
    check({tag, ".b_count"}, 64'(b_count), 64'(cnt));
    check({tag, ".b_sat"},   64'(b_sat),   64'(st));
  endtask

  initial begin
    rst = 1'b1; sum_valid = 1'b0; sum = '0; ovf = 1'b0; flush = 1'b0; ready = 1'b1;
    repeat (2) idle();
    check_a("rst_init", 1'b0, 40'h0, 3'd0, 1'b0);
    check_b("rst_init", 1'b0, 33'h0, 3'd0, 1'b0);

    // Reset held three cycles in the middle of a batch.
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 1'b0, 32'd100, 1'b0);
    drive(1'b1, 1'b0, 32'd200, 1'b0);
    @(negedge clk); sum_valid = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check_a("rst_mid", 1'b0, 40'h0, 3'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel.a_ready", 64'(a_sum_ready), 64'd1);
    check("rst_rel.b_ready", 64'(b_sum_ready), 64'd1);

    // Full batch; also proves the mid-batch reset left acc at zero.
    drive(1'b1, 1'b0, 32'd1, 1'b0);
    drive(1'b1, 1'b0, 32'd2, 1'b0);
    drive(1'b1, 1'b0, 32'd3, 1'b0);
    drive(1'b1, 1'b1, 32'd0, 1'b0);
    idle();
    check_a("full", 1'b1, 40'h1_0000_0006, 3'd4, 1'b0);
    check_b("full", 1'b1, 33'h1_0000_0006, 3'd4, 1'b0);
    check("full.a_ready", 64'(a_sum_ready), 64'd0);
    idle();
    check("full_pulse.a_valid", 64'(a_valid), 64'd0);
    check("full_pulse.a_ready", 64'(a_sum_ready), 64'd1);

    // Saturation on the 33-bit instance; 40-bit instance holds the exact sum.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    idle();
    check_a("sat", 1'b1, 40'h7_FFFF_FFFC, 3'd4, 1'b0);
    check_b("sat", 1'b1, 33'h1_FFFF_FFFF, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'd1, 1'b0);
    idle();
    check_a("post_sat", 1'b1, 40'd4, 3'd4, 1'b0);
    check_b("post_sat", 1'b1, 33'd4, 3'd4, 1'b0);

    // Flush with a beat in the same cycle includes that beat.
    drive(1'b1, 1'b0, 32'd5, 1'b0);
    drive(1'b1, 1'b0, 32'd7, 1'b0);
    drive(1'b1, 1'b0, 32'd9, 1'b1);
    idle();
    check_a("flush", 1'b1, 40'd21, 3'd3, 1'b0);
    check_b("flush", 1'b1, 33'd21, 3'd3, 1'b0);
    idle();
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    idle();
    check("flush_empty.a_valid", 64'(a_valid), 64'd0);
    idle();
    check("flush_empty2.a_valid", 64'(a_valid), 64'd0);
    check("flush_empty.a_ready", 64'(a_sum_ready), 64'd1);

    // Backpressure: outputs frozen while i_ready is low.
    ready = 1'b0;
    drive(1'b1, 1'b0, 32'd10, 1'b0);
    drive(1'b1, 1'b0, 32'd20, 1'b0);
    drive(1'b1, 1'b0, 32'd30, 1'b0);
    drive(1'b1, 1'b0, 32'd40, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle();
      check_a("bp_hold", 1'b1, 40'd100, 3'd4, 1'b0);
      check("bp_hold.a_ready", 64'(a_sum_ready), 64'd0);
    end
    ready = 1'b1;
    idle();
    check("bp_release.a_valid", 64'(a_valid), 64'd0);
    check("bp_release.a_ready", 64'(a_sum_ready), 64'd1);
    check("bp_release.a_acc", 64'(a_acc), 64'd100);

    // Reset while holding a result discards it.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'd50, 1'b0);
    idle();
    check("rst_hold_pre.a_valid", 64'(a_valid), 64'd1);
    rst = 1'b1;
    idle();
    check_a("rst_hold", 1'b0, 40'd0, 3'd0, 1'b0);
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'd2, 1'b0);
    idle();
    check_a("after_rst", 1'b1, 40'd8, 3'd4, 1'b0);
    check_b("after_rst", 1'b1, 33'd8, 3'd4, 1'b0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sum_accumulator

`default_nettype wire
